// File: rtl/out_display_driver.sv
// out_display_driver
// Converts the CPU output register to signed/unsigned decimal with a
// sequential double-dabble engine and drives a 4-digit multiplexed
// common-cathode 7-segment display (sign, hundreds, tens, ones). The ones
// digit decimal point shows the CPU halt flag.
module out_display_driver #(
    parameter int unsigned SCAN_DIV = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] value,
    input  logic       signed_mode,
    input  logic       halted,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] digit_sel,
    output logic       busy
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_ZERO  = 7'b0111111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_LOAD
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------
    // Decimal digit to active-high {g,f,e,d,c,b,a}; non-decimal codes blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Double-dabble correction: a nibble >= 5 gets +3 before the shift.
    function automatic logic [3:0] dabble_adj(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    // ------------------------------------------------------------------
    // Conversion state
    // ------------------------------------------------------------------
    state_t      state_q;
    logic [8:0]  snap_q;       // {signed_mode, value} of the last started conversion
    logic        force_q;      // forces a conversion after reset
    logic [7:0]  mag_q;        // magnitude being shifted into the BCD accumulator
    logic        neg_conv_q;   // sign of the conversion in flight
    logic [11:0] bcd_q;        // {H, T, O} accumulator
    logic [3:0]  iter_q;       // double-dabble iteration count
    logic        busy_q;

    // Display registers, updated only in LOAD
    logic [3:0]  disp_h_q;
    logic [3:0]  disp_t_q;
    logic [3:0]  disp_o_q;
    logic        disp_neg_q;

    // ------------------------------------------------------------------
    // Conversion datapath
    // ------------------------------------------------------------------
    logic [8:0]  sample_w;
    logic        start_req_w;
    logic        neg_in_w;
    logic [7:0]  mag_in_w;
    logic [3:0]  t_adj_w;
    logic [3:0]  o_adj_w;
    logic [11:0] bcd_d;
    logic [7:0]  mag_d;

    assign sample_w    = {signed_mode, value};
    assign start_req_w = (sample_w != snap_q) || force_q;
    assign neg_in_w    = signed_mode & value[7];
    // Two's-complement negate as 8-bit unsigned, so 0x80 yields 128.
    assign mag_in_w    = neg_in_w ? (~value + 8'd1) : value;

    // The hundreds nibble of an 8-bit magnitude never exceeds 2, so it never
    // needs the +3 correction; only tens and ones are adjusted.
    assign t_adj_w = dabble_adj(bcd_q[7:4]);
    assign o_adj_w = dabble_adj(bcd_q[3:0]);
    assign bcd_d   = {bcd_q[10:8], t_adj_w, o_adj_w, mag_q[7]};
    assign mag_d   = {mag_q[6:0], 1'b0};

    // Conversion FSM: snapshot on change, 8 dabble iterations, load display.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: all sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its peers.
        if (reset) begin
            state_q    <= ST_IDLE;
            snap_q     <= '0;
            force_q    <= 1'b1;
            mag_q      <= '0;
            neg_conv_q <= 1'b0;
            bcd_q      <= '0;
            iter_q     <= '0;
            busy_q     <= 1'b0;
            disp_h_q   <= '0;
            disp_t_q   <= '0;
            disp_o_q   <= '0;
            disp_neg_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_req_w) begin
                        snap_q     <= sample_w;
                        mag_q      <= mag_in_w;
                        neg_conv_q <= neg_in_w;
                        bcd_q      <= '0;
                        iter_q     <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    bcd_q  <= bcd_d;
                    mag_q  <= mag_d;
                    iter_q <= iter_q + 4'd1;
                    if (iter_q == 4'd7) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    disp_h_q   <= bcd_q[11:8];
                    disp_t_q   <= bcd_q[7:4];
                    disp_o_q   <= bcd_q[3:0];
                    disp_neg_q <= neg_conv_q;
                    force_q    <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;

    // ------------------------------------------------------------------
    // Digit scan
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] scan_cnt_q;
    logic [CNT_W-1:0] scan_cnt_d;
    logic [1:0]       digit_idx_q;
    logic [1:0]       digit_idx_d;
    logic             scan_wrap_w;

    assign scan_wrap_w = (scan_cnt_q == CNT_MAX);
    assign scan_cnt_d  = scan_wrap_w ? '0 : (scan_cnt_q + CNT_W'(1));
    assign digit_idx_d = scan_wrap_w ? (digit_idx_q + 2'd1) : digit_idx_q;

    // Scan counter and digit index run freely, independent of conversion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt_q  <= '0;
            digit_idx_q <= '0;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            digit_idx_q <= digit_idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Segment selection with leading-zero blanking
    // ------------------------------------------------------------------
    // Outputs are registered from the next digit index, so the registered
    // digit_sel tracks the index itself and each digit stays on SCAN_DIV cycles.
    logic [6:0] seg_d;

    // Pick the segment pattern for the digit about to be enabled.
    always_comb begin
        // NOTE: default assignment first so no path leaves seg_d unassigned
        // (which would infer a latch).
        seg_d = SEG_BLANK;
        case (digit_idx_d)
            2'd0: seg_d = seg7(disp_o_q);
            2'd1: seg_d = ((disp_h_q == 4'd0) && (disp_t_q == 4'd0)) ? SEG_BLANK
                                                                      : seg7(disp_t_q);
            2'd2: seg_d = (disp_h_q == 4'd0) ? SEG_BLANK : seg7(disp_h_q);
            2'd3: seg_d = disp_neg_q ? SEG_DASH : SEG_BLANK;
            default: seg_d = SEG_BLANK;
        endcase
    end

    logic [6:0] seg_q;
    logic [3:0] digit_sel_q;
    logic       dp_q;

    // Registered display outputs; dp follows halted only on the ones digit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q       <= SEG_ZERO;
            digit_sel_q <= 4'b0001;
            dp_q        <= 1'b0;
        end else begin
            seg_q       <= seg_d;
            digit_sel_q <= 4'b0001 << digit_idx_d;
            dp_q        <= halted & (digit_idx_d == 2'd0);
        end
    end

    assign seg       = seg_q;
    assign digit_sel = digit_sel_q;
    assign dp        = dp_q;

endmodule
